// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch stage. Holds the MIPS
// opcode/funct codes the fetch stage decodes, the fetch FSM state encodings
// and the default reset PC.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam logic [5:0]  OP_SPECIAL       = 6'h00;
   localparam logic [5:0]  FUNCT_SYSCALL    = 6'h0C;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_S = 2'd0,
      ISSUE_S = 2'd1,
      HALT_S  = 2'd2
   } fetch_state_e;

   // SYSCALL lives in the SPECIAL opcode space, so the funct field decides it.
   function automatic logic is_syscall(input logic [31:0] word);
      return (word[31:26] == OP_SPECIAL) && (word[5:0] == FUNCT_SYSCALL);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction memory request/ready bus between the fetch stage and memory.
//   imem_req   : fetch request (fetch -> memory)
//   imem_addr  : fetch address (fetch -> memory)
//   imem_ready : rdata is valid this cycle (memory -> fetch)
//   imem_rdata : instruction word (memory -> fetch)
// -----------------------------------------------------------------------------
interface fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_unit_pc_next_logic.sv
// -----------------------------------------------------------------------------
// pc_next_logic
// Purely combinational next-PC selection for the fetch stage.
//   instr        : held instruction (jump index and branch offset fields)
//   pc_plus4     : address of the held instruction plus 4
//   branch/branch_taken, jump/jump_reg : resolved control from execute
//   jr_target    : register value for JR
//   next_pc      : selected next PC
//   misaligned   : next_pc is not word aligned
// -----------------------------------------------------------------------------
module pc_next_logic (
   input  logic [31:0] instr,
   input  logic [31:0] pc_plus4,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        jump_reg,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] branch_offset;
   logic        unused_opcode;

   // Opcode bits are decoded upstream; only the index/offset fields matter here.
   assign unused_opcode = ^instr[31:26];

   assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

   // JR beats J/JAL beats a taken branch; everything else falls through.
   always_comb begin
      next_pc = pc_plus4;
      if (jump && jump_reg) begin
         next_pc = jr_target;
      end else if (jump) begin
         next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end else if (branch && branch_taken) begin
         next_pc = pc_plus4 + branch_offset;
      end
   end

   assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Holds the PC, fetches a word over the imem bus,
// presents it stable to control/datapath until execute reports done, then
// moves to the next PC. Stops on SYSCALL or a misaligned next PC.
//   clk, reset        : clock, synchronous active-high reset
//   imem              : instruction memory request/ready bus (master side)
//   instr/instr_valid : held instruction and its valid flag
//   pc/pc_plus4       : address of instr and the JAL link value
//   done              : execute finished instr; next-PC inputs valid
//   branch, branch_taken, jump, jump_reg, jr_target : next-PC resolution
//   halt/fault        : fetch stopped / stopped on misaligned target
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   fetch_unit_if.master imem,
   output logic [31:0]  instr,
   output logic         instr_valid,
   output logic [31:0]  pc,
   output logic [31:0]  pc_plus4,
   input  logic         done,
   input  logic         branch,
   input  logic         branch_taken,
   input  logic         jump,
   input  logic         jump_reg,
   input  logic [31:0]  jr_target,
   output logic         halt,
   output logic         fault
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         fault_q, fault_d;
   logic [31:0]  next_pc;
   logic         next_misaligned;

   assign pc_plus4 = pc_q + 32'd4;

   pc_next_logic u_pc_next (
      .instr        (instr_q),
      .pc_plus4     (pc_plus4),
      .branch       (branch),
      .branch_taken (branch_taken),
      .jump         (jump),
      .jump_reg     (jump_reg),
      .jr_target    (jr_target),
      .next_pc      (next_pc),
      .misaligned   (next_misaligned)
   );

   // State, PC, instruction and fault registers; reset abandons any
   // in-flight request or instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH_S;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0000_0000;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fault_q <= fault_d;
      end
   end

   // instr only loads on the edge leaving FETCH and pc only on a clean done,
   // so a SYSCALL or misaligned target leaves pc pointing at the culprit.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      fault_d = fault_q;
      case (state_q)
         FETCH_S: begin
            if (imem.imem_ready) begin
               instr_d = imem.imem_rdata;
               state_d = ISSUE_S;
            end
         end
         ISSUE_S: begin
            if (done) begin
               if (is_syscall(instr_q)) begin
                  state_d = HALT_S;
               end else if (next_misaligned) begin
                  state_d = HALT_S;
                  fault_d = 1'b1;
               end else begin
                  pc_d    = next_pc;
                  state_d = FETCH_S;
               end
            end
         end
         HALT_S: begin
            state_d = HALT_S;
         end
         default: begin
            state_d = FETCH_S;
         end
      endcase
   end

   assign imem.imem_req  = (state_q == FETCH_S);
   assign imem.imem_addr = pc_q;
   assign instr_valid    = (state_q == ISSUE_S);
   assign halt           = (state_q == HALT_S);
   assign instr          = instr_q;
   assign pc             = pc_q;
   assign fault          = fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the MIPS core; sits directly upstream of the control decoder. Holds the PC and fetches words from instruction memory over a req/ready handshake. Presents a stable `instr` to control and the datapath until execute signals completion. Then computes the next PC from branch/jump resolution. Halts on SYSCALL or a misaligned target.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req`=1.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  held instruction, drives control and datapath.
- `instr_valid`  out  1  `instr` is valid and awaiting execution.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4 (JAL link value).
- `done`  in  1  execute has finished `instr`; next-PC inputs are valid this cycle.
- `branch`, `branch_taken`  in  1,1  branch instruction; condition resolved by datapath (BEQ/BNE).
- `jump`, `jump_reg`  in  1,1  J/JAL; JR (qualifies `jump`).
- `jr_target`  in  32  register value for JR.
- `halt`  out  1  fetch stopped.
- `fault`  out  1  stopped due to misaligned next PC.

## Operation
- Three states: FETCH, ISSUE, HALT.
- FETCH:
  - `imem_req`=1; `imem_addr`=`pc`, held stable until `imem_ready`.
  - On `imem_ready`: `instr`<=`imem_rdata`, go ISSUE.
- ISSUE:
  - `instr_valid`=1; `instr` and `pc` frozen.
  - On `done`: `pc`<=next PC, go FETCH.
  - On `done` with SYSCALL: go HALT. SYSCALL is opcode SPECIAL with funct SYSCALL.
- HALT: `halt`=1, no requests; left only by `reset`.
- Next PC, priority highest first:
  - `jump`&`jump_reg` -> `jr_target`.
  - `jump` -> {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  - `branch`&`branch_taken` -> `pc_plus4` + (sign-extend `instr`[15:0] << 2).
  - else `pc_plus4`.
- All adds are 32-bit, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- No branch delay slot.
- Misaligned target: next PC with [1:0]≠0 at `done` -> HALT, `fault`=1, `pc` not updated.
- `done` outside ISSUE is ignored; `imem_ready` outside FETCH is ignored.

## Timing
- Reset (cycle `reset` sampled high): `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `halt`=0, `fault`=0, state=FETCH.
  - `imem_req`=1 from the first cycle after reset.
  - `imem_req`, `instr_valid` and `halt` are decoded from the state register.
- Minimum 2 cycles per instruction: `imem_ready` in the first FETCH cycle, `done` in the first ISSUE cycle.
  - Each memory wait cycle adds 1 cycle.
- `instr` changes only on the edge leaving FETCH. Control sees a new value exactly once per instruction.
- Reset mid-fetch or mid-issue abandons the in-flight request or instruction.
  - Memory must tolerate a dropped request.
- `reset` has priority over `done`, `imem_ready` and the halt transitions.
- `done` and SYSCALL in the same cycle: HALT; `pc` keeps the SYSCALL address.

## Structure
- Shared header `mips.h` holds opcode/funct defines (`SPECIAL`, `SYSCALL`, `J`, `JAL`, `BEQ`, `BNE`).
  - Add the state encodings `FETCH_S`/`ISSUE_S`/`HALT_S` and the default reset PC there.
- One combinational sub-module, `pc_next_logic`: inputs `instr`, `pc_plus4`, the branch/jump controls and `jr_target`; outputs next PC and misalign flag.
- The FSM, PC register and instruction register stay in `fetch_unit`.

## Test plan
- Sequential fetch: memory returns ADDI words with `imem_ready` immediate, `done` each ISSUE cycle -> `imem_addr` 0,4,8,…; one instruction per 2 cycles.
- Wait states: `imem_ready` delayed 3 cycles -> `imem_addr` stable 4 cycles, `instr_valid` low throughout, `instr` captured on the ready edge.
- Branch taken: BEQ at pc 0x10, imm 0xFFFF, `branch`=`branch_taken`=1 -> next `imem_addr`=0x10. With `branch_taken`=0 -> 0x14.
- Jumps:
  - J at 0x1000_0000 with target field 0x000_0040 -> 0x1000_0100.
  - JR with `jr_target`=0x0000_2000 -> 0x2000.
  - JR with `jr_target`=0x2002 -> `halt`=`fault`=1, `pc` unchanged.
- SYSCALL: opcode 0, funct SYSCALL, `done` -> `halt`=1 and `imem_req`=0 for 20 cycles. `reset` then restarts fetch at `RESET_PC`.
- Reset mid-wait: `reset` during FETCH with `imem_ready`=0 -> next cycle `pc`=`RESET_PC`, `instr_valid`=0, `imem_req`=1.
